// File: rtl/hello_msg_sequencer.sv
// Streams "Hello, World!" (optional LF) byte by byte to a valid/ready sink, N times per start.
// Latency: start in IDLE at T gives first byte at T+1; last transfer at L gives done_o at L+1.
// Backpressure: tx_valid_o/tx_data_o hold until tx_ready_i; one byte per cycle with ready held high.
module hello_msg_sequencer #(
    parameter int APPEND_NL  = 1,
    parameter int REPEAT_W   = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [REPEAT_W-1:0] repeat_i,
    input  logic                abort_i,
    output logic [7:0]          tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                aborted_o,
    output logic [REPEAT_W-1:0] msg_count_o
);
    localparam int         MSG_LEN  = (APPEND_NL != 0) ? 14 : 13;
    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);
    localparam int         GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [REPEAT_W-1:0] remain_q, remain_d;
    logic [REPEAT_W-1:0] count_q, count_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                abort_q, abort_d;
    logic                aborted_q, aborted_d;
    logic                last_byte;
    logic                abort_any;

    function automatic logic [7:0] rom_byte(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h48;
            4'd1:    return 8'h65;
            4'd2:    return 8'h6C;
            4'd3:    return 8'h6C;
            4'd4:    return 8'h6F;
            4'd5:    return 8'h2C;
            4'd6:    return 8'h20;
            4'd7:    return 8'h57;
            4'd8:    return 8'h6F;
            4'd9:    return 8'h72;
            4'd10:   return 8'h6C;
            4'd11:   return 8'h64;
            4'd12:   return 8'h21;
            4'd13:   return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    assign last_byte = (idx_q == LAST_IDX);
    // An abort pulse in the current cycle counts as well as one latched earlier.
    assign abort_any = abort_q | abort_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            remain_q  <= '0;
            count_q   <= '0;
            gap_q     <= '0;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            remain_q  <= remain_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
            abort_q   <= abort_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        remain_d  = remain_q;
        count_d   = count_q;
        gap_d     = gap_q;
        abort_d   = abort_q;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (start_i) begin
                    state_d  = S_SEND;
                    idx_d    = '0;
                    count_d  = '0;
                    remain_d = (repeat_i == '0) ? REPEAT_W'(1) : repeat_i;
                end
            end
            S_SEND: begin
                abort_d = abort_any;
                if (tx_ready_i) begin
                    if (last_byte) begin
                        idx_d    = '0;
                        count_d  = count_q + 1'b1;
                        remain_d = remain_q - 1'b1;
                        // Finishing the final message is a normal end even if abort arrived.
                        if (remain_q == REPEAT_W'(1)) begin
                            state_d = S_DONE;
                        end else if (abort_any) begin
                            state_d   = S_DONE;
                            aborted_d = 1'b1;
                        end else if (GAP_CYCLES > 0) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                        if (abort_any) begin
                            state_d   = S_DONE;
                            aborted_d = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                abort_d = abort_any;
                if (abort_any) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (gap_q == GAP_LAST) begin
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DONE: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        busy_o     = (state_q != S_IDLE);
        done_o     = 1'b0;
        aborted_o  = 1'b0;
        case (state_q)
            S_SEND: begin
                tx_valid_o = 1'b1;
                tx_data_o  = rom_byte(idx_q);
            end
            S_DONE: begin
                done_o    = 1'b1;
                aborted_o = aborted_q;
            end
            default: ;
        endcase
    end

    assign msg_count_o = count_q;

endmodule

// File: tb/tb_hello_msg_sequencer.sv
// Bench for hello_msg_sequencer: three configurations checked every cycle against a byte-count model.
module tb_hello_msg_sequencer;
    localparam int N  = 3;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start   [N];
    logic [RW-1:0] rep     [N];
    logic          abort   [N];
    logic          ready   [N];
    logic [7:0]    data    [N];
    logic          valid   [N];
    logic          busy    [N];
    logic          done    [N];
    logic          aborted [N];
    logic [RW-1:0] cnt     [N];

    always #5 clk = ~clk;

    hello_msg_sequencer #(.APPEND_NL(1), .REPEAT_W(RW), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start[0]), .repeat_i(rep[0]), .abort_i(abort[0]),
        .tx_data_o(data[0]), .tx_valid_o(valid[0]), .tx_ready_i(ready[0]), .busy_o(busy[0]),
        .done_o(done[0]), .aborted_o(aborted[0]), .msg_count_o(cnt[0]));
    hello_msg_sequencer #(.APPEND_NL(1), .REPEAT_W(RW), .GAP_CYCLES(4)) dut1 (
        .clk(clk), .rst(rst), .start_i(start[1]), .repeat_i(rep[1]), .abort_i(abort[1]),
        .tx_data_o(data[1]), .tx_valid_o(valid[1]), .tx_ready_i(ready[1]), .busy_o(busy[1]),
        .done_o(done[1]), .aborted_o(aborted[1]), .msg_count_o(cnt[1]));
    hello_msg_sequencer #(.APPEND_NL(0), .REPEAT_W(RW), .GAP_CYCLES(0)) dut2 (
        .clk(clk), .rst(rst), .start_i(start[2]), .repeat_i(rep[2]), .abort_i(abort[2]),
        .tx_data_o(data[2]), .tx_valid_o(valid[2]), .tx_ready_i(ready[2]), .busy_o(busy[2]),
        .done_o(done[2]), .aborted_o(aborted[2]), .msg_count_o(cnt[2]));

    logic [7:0] msg [14] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                             8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
    int len_c [N] = '{14, 14, 13};
    int gap_c [N] = '{0, 4, 0};

    // Model: bytes sent so far versus total owed, plus idle countdown and pending done.
    bit         m_active [N];
    bit         m_done   [N];
    bit         m_abt    [N];
    bit         m_pend   [N];
    int         m_sent   [N];
    int         m_total  [N];
    int         m_gap    [N];
    bit         prev_hold[N];
    logic [7:0] prev_data[N];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       st;
        logic [7:0] rp;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_busy;
        logic       e_done;
        logic       e_abt;
        logic [7:0] e_cnt;
    } vec_t;
    vec_t tbl [17];

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_active[k] = 0; m_done[k] = 0; m_abt[k] = 0; m_pend[k] = 0;
        m_sent[k] = 0; m_total[k] = 0; m_gap[k] = 0; prev_hold[k] = 0; prev_data[k] = 8'h00;
    endtask

    task automatic finish_seq(input int k, input bit was_abort);
        m_active[k] = 0;
        m_done[k]   = 1;
        m_abt[k]    = was_abort;
    endtask

    task automatic compare_all(input int k);
        bit         ev;
        logic [7:0] ed;
        ev = m_active[k] && (m_gap[k] == 0);
        ed = msg[m_sent[k] % len_c[k]];
        check("busy", k, 32'(busy[k]), 32'(m_active[k] || m_done[k]));
        check("valid", k, 32'(valid[k]), 32'(ev));
        if (ev) check("data", k, 32'(data[k]), 32'(ed));
        check("done", k, 32'(done[k]), 32'(m_done[k]));
        check("aborted", k, 32'(aborted[k]), 32'(m_done[k] && m_abt[k]));
        check("msg_count", k, 32'(cnt[k]), 32'(m_sent[k] / len_c[k]));
        if (prev_hold[k]) begin
            check("hold_valid", k, 32'(valid[k]), 32'd1);
            check("hold_data", k, 32'(data[k]), 32'(prev_data[k]));
        end
        prev_hold[k] = ev && !ready[k];
        prev_data[k] = ed;
    endtask

    task automatic model_step(input int k);
        bit ab;
        if (rst) begin
            model_reset(k);
        end else if (m_done[k]) begin
            m_done[k] = 0;
        end else if (!m_active[k]) begin
            if (start[k]) begin
                m_active[k] = 1;
                m_sent[k]   = 0;
                m_total[k]  = ((rep[k] == 0) ? 1 : int'(rep[k])) * len_c[k];
                m_gap[k]    = 0;
                m_pend[k]   = 0;
            end
        end else begin
            ab = m_pend[k] || abort[k];
            if (m_gap[k] > 0) begin
                if (ab) finish_seq(k, 1);
                else m_gap[k]--;
            end else if (ready[k]) begin
                m_sent[k]++;
                if (m_sent[k] == m_total[k]) finish_seq(k, 0);
                else if (ab) finish_seq(k, 1);
                else if (m_sent[k] % len_c[k] == 0) m_gap[k] = gap_c[k];
            end
            m_pend[k] = m_active[k] && ab;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < N; k++) compare_all(k);
        for (int k = 0; k < N; k++) model_step(k);
        @(posedge clk);
        #1;
    endtask

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, lows, dones;
        bit  seen;
        logic [7:0] last;

        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            start[k] = 0; rep[k] = '0; abort[k] = 0; ready[k] = 0;
            model_reset(k);
        end
        #1;
        for (int k = 0; k < N; k++) begin
            check("rst_valid", k, 32'(valid[k]), 32'd0);
            check("rst_busy", k, 32'(busy[k]), 32'd0);
            check("rst_done", k, 32'(done[k]), 32'd0);
            check("rst_count", k, 32'(cnt[k]), 32'd0);
            check("rst_data", k, 32'(data[k]), 32'd0);
        end
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        // Single message, ready held high: table of per-cycle expectations.
        for (int i = 0; i < 17; i++) begin
            tbl[i] = '{default: '0};
            tbl[i].rdy = 1'b1;
            if (i >= 1 && i <= 14) begin
                tbl[i].e_valid = 1'b1;
                tbl[i].e_data  = msg[i-1];
                tbl[i].e_busy  = 1'b1;
            end
        end
        tbl[0].st = 1'b1; tbl[0].rp = 8'd1;
        tbl[15].e_busy = 1'b1; tbl[15].e_done = 1'b1; tbl[15].e_cnt = 8'd1;
        tbl[16].e_cnt = 8'd1;
        for (int i = 0; i < 17; i++) begin
            start[0] = tbl[i].st; rep[0] = tbl[i].rp; ready[0] = tbl[i].rdy;
            #2;
            check("tbl_valid", 0, 32'(valid[0]), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) check("tbl_data", 0, 32'(data[0]), 32'(tbl[i].e_data));
            check("tbl_busy", 0, 32'(busy[0]), 32'(tbl[i].e_busy));
            check("tbl_done", 0, 32'(done[0]), 32'(tbl[i].e_done));
            check("tbl_aborted", 0, 32'(aborted[0]), 32'(tbl[i].e_abt));
            check("tbl_count", 0, 32'(cnt[0]), 32'(tbl[i].e_cnt));
            cycle();
        end

        // Ready toggling 1,0,1,0: exactly 14 transfers in order.
        rep[0] = 8'd1; start[0] = 1; cycle(); start[0] = 0;
        n = 0; seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            ready[0] = (c % 2 == 0);
            if (valid[0] && ready[0]) begin
                if (n < 14) check("t2_byte", 0, 32'(data[0]), 32'(msg[n]));
                n++;
            end
            if (done[0]) seen = 1;
            cycle();
        end
        check("t2_transfers", 0, n, 14);
        check("t2_done_seen", 0, 32'(seen), 32'd1);

        // Three messages with four idle cycles between them.
        ready[1] = 1; rep[1] = 8'd3; start[1] = 1; cycle(); start[1] = 0;
        n = 0; lows = 0; dones = 0;
        for (int c = 0; c < 200; c++) begin
            if (valid[1]) n++;
            else if (busy[1] && !done[1] && n > 0) lows++;
            if (done[1]) dones++;
            if (dones > 0 && !busy[1]) break;
            cycle();
        end
        check("t3_bytes", 1, n, 42);
        check("t3_gap_cycles", 1, lows, 8);
        check("t3_dones", 1, dones, 1);
        check("t3_count", 1, 32'(cnt[1]), 32'd3);

        // Abort pulsed while 0x6F is held by backpressure.
        ready[0] = 1; rep[0] = 8'd2; start[0] = 1; cycle(); start[0] = 0;
        repeat (4) cycle();
        ready[0] = 0;
        check("t4_held_byte", 0, 32'(data[0]), 32'h6F);
        abort[0] = 1; cycle(); abort[0] = 0;
        repeat (2) begin
            check("t4_hold_valid", 0, 32'(valid[0]), 32'd1);
            check("t4_hold_data", 0, 32'(data[0]), 32'h6F);
            cycle();
        end
        ready[0] = 1; cycle();
        check("t4_done", 0, 32'(done[0]), 32'd1);
        check("t4_aborted", 0, 32'(aborted[0]), 32'd1);
        check("t4_valid", 0, 32'(valid[0]), 32'd0);
        check("t4_count", 0, 32'(cnt[0]), 32'd0);
        cycle();
        check("t4_idle", 0, 32'(busy[0]), 32'd0);
        check("t4_aborted_low", 0, 32'(aborted[0]), 32'd0);

        // Asynchronous reset in the middle of a message.
        rep[0] = 8'd1; start[0] = 1; cycle(); start[0] = 0;
        repeat (7) cycle();
        check("t5_idx7", 0, 32'(data[0]), 32'h57);
        #2 rst = 1'b1;
        for (int k = 0; k < N; k++) model_reset(k);
        #1;
        check("t5_valid", 0, 32'(valid[0]), 32'd0);
        check("t5_data", 0, 32'(data[0]), 32'd0);
        check("t5_busy", 0, 32'(busy[0]), 32'd0);
        check("t5_done", 0, 32'(done[0]), 32'd0);
        cycle();
        rst = 1'b0;
        cycle();
        start[0] = 1; cycle(); start[0] = 0;
        check("t5_first", 0, 32'(data[0]), 32'h48);
        check("t5_count", 0, 32'(cnt[0]), 32'd0);
        repeat (16) cycle();

        // Start held high while busy (including the DONE cycle); repeat 0 gives one message.
        rep[0] = '0; start[0] = 1; cycle();
        n = 0; seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (valid[0] && ready[0]) n++;
            if (done[0]) seen = 1;
            cycle();
        end
        start[0] = 0;
        check("t6_transfers", 0, n, 14);
        check("t6_done_seen", 0, 32'(seen), 32'd1);
        check("t6_idle", 0, 32'(busy[0]), 32'd0);
        check("t6_count", 0, 32'(cnt[0]), 32'd1);

        // No trailing newline: 13 bytes ending with '!'.
        ready[2] = 1; rep[2] = 8'd1; start[2] = 1; cycle(); start[2] = 0;
        n = 0; seen = 0; last = 8'h00;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (valid[2]) begin n++; last = data[2]; end
            if (done[2]) seen = 1;
            cycle();
        end
        check("t6_nl0_bytes", 2, n, 13);
        check("t6_nl0_last", 2, 32'(last), 32'h21);
        check("t6_nl0_done", 2, 32'(seen), 32'd1);

        // Random traffic on all three instances.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                start[k] = ($urandom_range(0, 5) == 0);
                rep[k]   = RW'($urandom_range(0, 3));
                abort[k] = ($urandom_range(0, 39) == 0);
                ready[k] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end
        for (int k = 0; k < N; k++) begin
            start[k] = 0; abort[k] = 0; ready[k] = 1;
        end
        repeat (100) cycle();
        for (int k = 0; k < N; k++) check("drain_idle", k, 32'(busy[k]), 32'd0);

        summary();
        $finish;
    end
endmodule
